// File: rtl/mem_map_ctrl.sv
// mem_map_ctrl: CPU memory map plus a framebuffer scan-out streamer.
//   General-purpose RAM at 0..RAM_DEPTH-1 (true dual port: A = CPU, B = scan-out).
//   A read-only keyboard register sits at KBD_ADDR. Any other address reads 0
//   and pulses cpu_err one cycle later.
//   The scan-out FSM streams VID_WORDS bitmap words over valid/ready.
//   Optional feature macro: MEM_VID_PAGE_EN adds a 1-bit video page register
//   at PAGE_ADDR. The page selects which of two bitmaps is scanned out.
// Ports:
//   clk, reset                         clock, async active-high reset
//   cpu_addr/cpu_wdata/cpu_we          CPU access (one word per cycle)
//   cpu_rdata, cpu_err                 registered read data, unmapped-access pulse
//   kbd_in                             asynchronous keyboard scancode
//   vid_start, vid_busy                frame start pulse, frame in progress
//   vid_valid/vid_ready/vid_data/vid_last  scan-out stream
module mem_map_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int RAM_DEPTH = 16384,
  parameter int VID_BASE  = 512,
  parameter int VID_WORDS = 1200,
  parameter int KBD_ADDR  = 24576,
  parameter int PAGE_ADDR = 24577
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic [DATA_W-1:0] kbd_in,
  input  logic              vid_start,
  output logic              vid_busy,
  output logic              vid_valid,
  input  logic              vid_ready,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_last
);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int NW     = $clog2(VID_WORDS + 1);
  localparam logic [ADDR_W:0]   RAM_END = (ADDR_W+1)'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] KBD_A   = ADDR_W'(KBD_ADDR);
  localparam logic [ADDR_W-1:0] PAGE_A  = ADDR_W'(PAGE_ADDR);
  localparam logic [ADDR_W-1:0] BASE0   = ADDR_W'(VID_BASE);
  localparam logic [ADDR_W-1:0] BASE1   = ADDR_W'(VID_BASE + VID_WORDS);
  localparam logic [NW-1:0]     N_END   = NW'(VID_WORDS);
  localparam logic [NW-1:0]     N_LAST  = NW'(VID_WORDS - 1);

  if (VID_BASE + VID_WORDS > RAM_DEPTH) begin : g_bad_map
    $error("mem_map_ctrl: bitmap window exceeds RAM");
  end
`ifdef MEM_VID_PAGE_EN
  if (VID_BASE + 2*VID_WORDS > RAM_DEPTH) begin : g_bad_page_map
    $error("mem_map_ctrl: second bitmap page exceeds RAM");
  end
`endif

  typedef enum logic {IDLE, RUN} state_t;

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  // ---------------- CPU port (A) ----------------
  logic              ram_hit, kbd_hit, page_hit, page_q;
  logic [RAM_AW-1:0] a_idx;
  logic [DATA_W-1:0] ram_q, misc_q, kbd_s1, kbd_s2;
  logic              sel_ram_q;

  assign ram_hit = {1'b0, cpu_addr} < RAM_END;
  assign kbd_hit = cpu_addr == KBD_A;
  assign a_idx   = RAM_AW'(cpu_addr);

`ifdef MEM_VID_PAGE_EN
  assign page_hit = cpu_addr == PAGE_A;
  always_ff @(posedge clk or posedge reset)
    if (reset)                   page_q <= 1'b0;
    else if (cpu_we && page_hit) page_q <= cpu_wdata[0];
`else
  logic unused_page;
  assign unused_page = cpu_addr == PAGE_A;
  assign page_hit    = 1'b0;
  assign page_q      = 1'b0;
`endif

  // Read-before-write: a same-cycle write returns the old word.
  always_ff @(posedge clk) begin
    if (cpu_we && ram_hit) mem[a_idx] <= cpu_wdata;
    ram_q <= mem[a_idx];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      kbd_s1    <= '0;
      kbd_s2    <= '0;
      sel_ram_q <= 1'b0;
      misc_q    <= '0;
      cpu_err   <= 1'b0;
    end else begin
      kbd_s1    <= kbd_in;
      kbd_s2    <= kbd_s1;
      sel_ram_q <= ram_hit;
      misc_q    <= kbd_hit  ? kbd_s2 :
                   page_hit ? DATA_W'(page_q) : '0;
      cpu_err   <= !(ram_hit || kbd_hit || page_hit);
    end

  // RAM output register has no reset, so the select flop forces 0 out of reset.
  assign cpu_rdata = sel_ram_q ? ram_q : misc_q;

  // ---------------- Scan-out (port B) ----------------
  state_t                  state_q, state_d;
  logic [NW-1:0]           n_q;
  logic [ADDR_W-1:0]       base_q;
  logic [RAM_AW-1:0]       rd_idx;
  logic [1:0][DATA_W-1:0]  f_data;   // [0] is the head
  logic [1:0]              f_last;
  logic [1:0]              f_cnt;
  logic                    issue, pop;

  // Port-B read data lands straight in a FIFO slot, so a read is never
  // "in flight" across a cycle boundary. Counting the same-cycle pop lets a
  // full-rate stream keep one slot busy and sustain one word per cycle.
  assign pop       = vid_valid && vid_ready;
  assign rd_idx    = RAM_AW'(base_q + ADDR_W'(n_q));
  assign vid_valid = f_cnt != 2'd0;
  assign vid_data  = f_data[0];
  assign vid_last  = f_last[0] && vid_valid;
  assign vid_busy  = state_q == RUN;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (vid_start) state_d = RUN;
      RUN: begin
        issue = (n_q != N_END) && ((f_cnt != 2'd2) || pop);
        if (pop && f_last[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      base_q  <= BASE0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && vid_start) begin
        n_q    <= '0;
        base_q <= page_q ? BASE1 : BASE0;   // page latched for the whole frame
      end else if (issue) begin
        n_q <= n_q + 1'b1;
      end
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      f_data <= '0;
      f_last <= '0;
      f_cnt  <= '0;
    end else begin
      case ({issue, pop})
        2'b10: begin
          if (f_cnt == 2'd0) begin
            f_data[0] <= mem[rd_idx];
            f_last[0] <= n_q == N_LAST;
          end else begin
            f_data[1] <= mem[rd_idx];
            f_last[1] <= n_q == N_LAST;
          end
          f_cnt <= f_cnt + 2'd1;
        end
        2'b01: begin
          f_data[0] <= f_data[1];
          f_last[0] <= f_last[1];
          f_cnt     <= f_cnt - 2'd1;
        end
        2'b11: begin
          if (f_cnt == 2'd1) begin
            f_data[0] <= mem[rd_idx];
            f_last[0] <= n_q == N_LAST;
          end else begin
            f_data[0] <= f_data[1];
            f_last[0] <= f_last[1];
            f_data[1] <= mem[rd_idx];
            f_last[1] <= n_q == N_LAST;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mem_map_ctrl.sv
module tb_mem_map_ctrl;
  localparam int VW = 1200;
  localparam int VB = 512;
  localparam int KBD = 24576;
  localparam int PAGE = 24577;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_rdata;
  logic        cpu_err;
  logic [15:0] kbd_in = '0;
  logic        vid_start = 1'b0;
  logic        vid_busy, vid_valid, vid_last;
  logic        vid_ready = 1'b0;
  logic [15:0] vid_data;

  mem_map_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .kbd_in(kbd_in),
    .vid_start(vid_start), .vid_busy(vid_busy), .vid_valid(vid_valid),
    .vid_ready(vid_ready), .vid_data(vid_data), .vid_last(vid_last)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] ref_mem [16384];   // behavioural RAM image

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input int a, input logic [15:0] d);
    cpu_addr = 15'(a); cpu_wdata = d; cpu_we = 1'b1;
    step();
    cpu_we = 1'b0; cpu_addr = '0;
    if (a < 16384) ref_mem[a] = d;
  endtask

  task automatic cpu_read(input int a, output logic [15:0] d, output logic e);
    cpu_addr = 15'(a); cpu_we = 1'b0;
    step();
    d = cpu_rdata; e = cpu_err;
    cpu_addr = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_err"},   cpu_err, 0);
    chk({tag, "_busy"},  vid_busy, 0);
    chk({tag, "_valid"}, vid_valid, 0);
    chk({tag, "_data"},  vid_data, 0);
    chk({tag, "_last"},  vid_last, 0);
  endtask

  // Streams one frame; expected word k is ref_mem[base+k].
  task automatic run_frame(input bit rnd, input int base, input bit restart_mid,
                           input int abort_at, input bit page_mid);
    int k = 0, cyc;
    bit held = 0, page_done = 0;
    logic [16:0] hold = '0;
    vid_ready = 1'b1;
    vid_start = 1'b1;
    step();
    vid_start = 1'b0;
    cyc = 1;
    chk("busy_after_start", vid_busy, 1);
    chk("valid_cycle1", vid_valid, 0);
    while (k < VW && cyc < 10000) begin
      if (abort_at >= 0 && k == abort_at) begin
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        return;
      end
      vid_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vid_valid) begin
        if (held) chk("stall_hold", {vid_last, vid_data}, hold);
        if (vid_ready) begin
          chk("word_data", vid_data, ref_mem[base + k]);
          chk("word_last", vid_last, k == VW - 1);
          if (!rnd) chk("word_timing", cyc, 2 + k);
          k++;
          held = 0;
        end else begin
          held = 1;
          hold = {vid_last, vid_data};
        end
      end else if (held) begin
        chk("valid_held", vid_valid, 1);
      end
      vid_start = restart_mid && k >= 300 && k < 305;
      if (page_mid && !page_done && k >= 100) begin
        cpu_addr = 15'(PAGE); cpu_wdata = 16'h0; cpu_we = 1'b1;
        page_done = 1;
      end
      step();
      cpu_we = 1'b0; cpu_addr = '0;
      cyc++;
    end
    vid_start = 1'b0;
    chk("frame_words", k, VW);
    chk("busy_end", vid_busy, 0);
    chk("valid_end", vid_valid, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [15:0] d, old;
    logic e;
    int a;

    // Reset state (asynchronous, before any clock edge)
    #1;
    chk_all_zero("reset");
    step(); step();
    reset = 1'b0;
    step();

    // 1. Basic RAM write/read
    cpu_write(5, 16'hBEEF);
    cpu_read(5, d, e);
    chk("ram_beef", d, 16'hBEEF);
    chk("ram_beef_err", e, 0);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 16383);
      cpu_write(a, 16'($urandom));
      cpu_read(a, d, e);
      chk("ram_rand", d, ref_mem[a]);
    end
    cpu_write(16383, 16'hC0DE);
    cpu_read(16383, d, e);
    chk("ram_top", d, 16'hC0DE);
    chk("ram_top_err", e, 0);

    // Same-cycle write returns old data
    cpu_write(7, 16'h1111);
    old = ref_mem[7];
    cpu_addr = 15'd7; cpu_wdata = 16'h2222; cpu_we = 1'b1;
    step();
    chk("rdw_old", cpu_rdata, old);
    cpu_we = 1'b0; cpu_addr = '0;
    ref_mem[7] = 16'h2222;
    cpu_read(7, d, e);
    chk("rdw_new", d, 16'h2222);

    // 2. Keyboard register and unmapped space
    kbd_in = 16'h0041;
    step(); step(); step();
    cpu_read(KBD, d, e);
    chk("kbd_41", d, 16'h0041);
    chk("kbd_err", e, 0);
    kbd_in = 16'($urandom);
    step(); step(); step();
    cpu_read(KBD, d, e);
    chk("kbd_rand", d, kbd_in);
    cpu_write(8192, 16'h5A5A);           // RAM alias of 0x6000 in low bits
    cpu_addr = 15'(KBD); cpu_wdata = 16'hFFFF; cpu_we = 1'b1;
    step();
    chk("kbd_write_err", cpu_err, 0);
    cpu_we = 1'b0; cpu_addr = '0;
    cpu_read(8192, d, e);
    chk("kbd_write_noram", d, ref_mem[8192]);
    cpu_write(12288, 16'h3C3C);          // RAM alias of 0x7000
    cpu_write(28672, 16'hDEAD);
    chk("unmapped_write_err", cpu_err, 1);
    cpu_read(28672, d, e);
    chk("unmapped_rdata", d, 0);
    chk("unmapped_err", e, 1);
    step();
    chk("unmapped_err_pulse", cpu_err, 0);
    cpu_read(12288, d, e);
    chk("unmapped_write_dropped", d, ref_mem[12288]);
`ifndef MEM_VID_PAGE_EN
    cpu_read(PAGE, d, e);
    chk("page_unmapped_rdata", d, 0);
    chk("page_unmapped_err", e, 1);
`endif

    // 3. Full-rate frame
    for (int i = 0; i < VW; i++) cpu_write(VB + i, 16'(i));
    run_frame(0, VB, 0, -1, 0);

    // 5. Reset mid-frame, then restart from word 0
    run_frame(0, VB, 0, 600, 0);
    step();
    reset = 1'b0;
    step();
    chk("post_abort_busy", vid_busy, 0);
    chk("post_abort_valid", vid_valid, 0);
    run_frame(0, VB, 0, -1, 0);

    // 4. Random data, random backpressure, ignored mid-frame vid_start
    for (int i = 0; i < VW; i++) cpu_write(VB + i, 16'($urandom));
    run_frame(1, VB, 1, -1, 0);

`ifdef MEM_VID_PAGE_EN
    // 6. Second bitmap page
    for (int i = 1; i < VW; i++) cpu_write(VB + VW + i, 16'($urandom));
    cpu_write(1712, 16'h1234);
    cpu_write(PAGE, 16'hFFFF);
    cpu_read(PAGE, d, e);
    chk("page_readback", d, 1);
    chk("page_err", e, 0);
    run_frame(0, VB + VW, 0, -1, 1);     // page cleared mid-frame
    cpu_read(PAGE, d, e);
    chk("page_cleared", d, 0);
    run_frame(1, VB, 0, -1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
